// File: rtl/bic_param.sv
// Bit index counter for the UART receive path: counts bit boundaries across
// a parametrised frame and reports frame completion or abort.
module bic_param #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY_EN = 0,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned SAMPLE_W  = 4,
  parameter int unsigned IDX_W     = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                flag,
  output logic [IDX_W-1:0]    bit_idx,
  output logic                bit_strobe,
  output logic                char_rs,
  output logic                busy,
  output logic                abort_err
);

  localparam int unsigned FRAME = 1 + DATA_BITS + PARITY_EN + STOP_BITS;
  localparam logic [IDX_W-1:0] FRAME_IDX = IDX_W'(FRAME);

  if ((2 ** IDX_W) <= FRAME) begin : g_idx_w_check
    $error("bic_param: IDX_W too small to hold FRAME");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_data_check
    $error("bic_param: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_check
    $error("bic_param: STOP_BITS must be 1..2");
  end
  if (PARITY_EN > 1) begin : g_parity_check
    $error("bic_param: PARITY_EN must be 0 or 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    COUNT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t           state, state_next;
  logic [IDX_W-1:0] count, count_next, count_inc;
  logic             strobe_next, char_next, abort_next;
  logic             tick;

  assign tick      = enable & (sample == '1);
  assign count_inc = count + 1'b1;
  assign bit_idx   = count;
  assign busy      = (state == COUNT) || (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      bit_strobe <= 1'b0;
      char_rs    <= 1'b0;
      abort_err  <= 1'b0;
    end else begin
      state      <= state_next;
      count      <= count_next;
      bit_strobe <= strobe_next;
      char_rs    <= char_next;
      abort_err  <= abort_next;
    end
  end

  // flag outranks everything, so it is decoded ahead of the state case.
  always_comb begin
    state_next  = state;
    count_next  = count;
    strobe_next = 1'b0;
    char_next   = 1'b0;
    abort_next  = 1'b0;
    if (flag) begin
      state_next = IDLE;
      count_next = '0;
      abort_next = (state == COUNT) || (state == DONE);
    end else begin
      case (state)
        IDLE: begin
          count_next = '0;
          if (tick) begin
            count_next  = {{(IDX_W-1){1'b0}}, 1'b1};
            strobe_next = 1'b1;
            state_next  = COUNT;
          end
        end
        COUNT: begin
          if (count > FRAME_IDX) begin
            count_next = '0;
            state_next = IDLE;
          end else if (tick) begin
            count_next  = count_inc;
            strobe_next = 1'b1;
            if (count_inc == FRAME_IDX) state_next = DONE;
          end
        end
        DONE: begin
          count_next = '0;
          char_next  = 1'b1;
          state_next = IDLE;
        end
        default: begin
          count_next = '0;
          state_next = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bic_param.sv
// Bench for bic_param: default frame and an 11-bit frame (7 data, parity,
// 2 stop) driven in parallel and checked each cycle against a count model.
module tb_bic_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       flag = 1'b0;
  logic [3:0] sample = 4'h0;

  logic [3:0] idx0, idx1;
  logic       stb0, stb1, chr0, chr1, busy0, busy1, ab0, ab1;

  always #5 clk = ~clk;

  bic_param d0 (
    .clk(clk), .rst(rst), .enable(enable), .sample(sample), .flag(flag),
    .bit_idx(idx0), .bit_strobe(stb0), .char_rs(chr0), .busy(busy0),
    .abort_err(ab0)
  );

  bic_param #(.DATA_BITS(7), .PARITY_EN(1), .STOP_BITS(2)) d1 (
    .clk(clk), .rst(rst), .enable(enable), .sample(sample), .flag(flag),
    .bit_idx(idx1), .bit_strobe(stb1), .char_rs(chr1), .busy(busy1),
    .abort_err(ab1)
  );

  // Model: the frame position alone determines behaviour. Position 0 is idle,
  // reaching the frame length means the completion cycle comes next.
  typedef struct {
    int idx;
    bit strobe;
    bit chr;
    bit ab;
  } mstate_t;

  mstate_t m0 = '{0, 1'b0, 1'b0, 1'b0};
  mstate_t m1 = '{0, 1'b0, 1'b0, 1'b0};
  int  n_cmp = 0;
  int  n_bad = 0;
  bit  chk_en = 1'b0;

  function automatic mstate_t step(input mstate_t s, input int frame);
    mstate_t n;
    bit tick;
    tick     = enable && (sample == 4'hF);
    n.idx    = s.idx;
    n.strobe = 1'b0;
    n.chr    = 1'b0;
    n.ab     = 1'b0;
    if (rst) n.idx = 0;
    else if (flag) begin
      n.ab  = (s.idx != 0);
      n.idx = 0;
    end else if (s.idx > frame) n.idx = 0;
    else if (s.idx == frame) begin
      n.idx = 0;
      n.chr = 1'b1;
    end else if (tick) begin
      n.idx    = s.idx + 1;
      n.strobe = 1'b1;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m0 = step(m0, 10);
    m1 = step(m1, 11);
  end

  task automatic cmp(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("d0.bit_idx", int'(idx0), m0.idx);
      cmp("d0.bit_strobe", int'(stb0), int'(m0.strobe));
      cmp("d0.char_rs", int'(chr0), int'(m0.chr));
      cmp("d0.abort_err", int'(ab0), int'(m0.ab));
      cmp("d0.busy", int'(busy0), int'(m0.idx != 0));
      cmp("d1.bit_idx", int'(idx1), m1.idx);
      cmp("d1.bit_strobe", int'(stb1), int'(m1.strobe));
      cmp("d1.char_rs", int'(chr1), int'(m1.chr));
      cmp("d1.abort_err", int'(ab1), int'(m1.ab));
      cmp("d1.busy", int'(busy1), int'(m1.idx != 0));
    end
  end

  // Applies one cycle of inputs; returns just after the following negedge,
  // when the outputs reflect that cycle.
  task automatic drive(input bit r, input bit e, input logic [3:0] s, input bit f);
    rst = r; enable = e; sample = s; flag = f;
    @(negedge clk); #1;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++)
      drive(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 14)), 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      gap($urandom_range(0, 3));
      drive(1'b0, 1'b1, 4'hF, 1'b0);
    end
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 4'h0, 1'b0);
  endtask

  initial begin
    @(negedge clk); #1;
    chk_en = 1'b1;
    drive(1'b1, 1'b0, 4'h0, 1'b0);
    cmp("rst.idx", int'(idx0), 0);
    cmp("rst.strobe", int'(stb0), 0);
    cmp("rst.char", int'(chr0), 0);
    cmp("rst.abort", int'(ab0), 0);
    cmp("rst.busy", int'(busy0), 0);

    // Full default frame, ticks 16 cycles apart.
    for (int k = 1; k <= 10; k++) begin
      gap(15);
      drive(1'b0, 1'b1, 4'hF, 1'b0);
      cmp("frame.idx", int'(idx0), k);
      cmp("frame.strobe", int'(stb0), 1);
    end
    idle();
    cmp("frame.done_idx", int'(idx0), 0);
    cmp("frame.char", int'(chr0), 1);
    cmp("frame11.hold10", int'(idx1), 10);
    idle();
    cmp("frame.char_single", int'(chr0), 0);
    cmp("frame.busy_after", int'(busy0), 0);

    // 11th tick completes the long frame; default frame restarts at 1.
    gap(15);
    drive(1'b0, 1'b1, 4'hF, 1'b0);
    cmp("frame11.peak", int'(idx1), 11);
    cmp("frame11.no_char_yet", int'(chr1), 0);
    cmp("restart.idx", int'(idx0), 1);
    idle();
    cmp("frame11.char", int'(chr1), 1);
    cmp("frame11.done_idx", int'(idx1), 0);
    drive(1'b0, 1'b0, 4'h0, 1'b1);
    cmp("abort.busy_err", int'(ab0), 1);
    cmp("abort.idle_noerr", int'(ab1), 0);

    // Abort after 4 ticks, flag coinciding with a tick.
    ticks(4);
    cmp("abort4.idx", int'(idx0), 4);
    drive(1'b0, 1'b1, 4'hF, 1'b1);
    cmp("abort4.idx_clr", int'(idx0), 0);
    cmp("abort4.err", int'(ab0), 1);
    cmp("abort4.no_strobe", int'(stb0), 0);
    cmp("abort4.no_char", int'(chr0), 0);
    idle();
    cmp("abort4.err_single", int'(ab0), 0);
    drive(1'b0, 1'b0, 4'h0, 1'b1);
    cmp("abort.idle_flag", int'(ab0), 0);

    // Non-tick patterns and enable dropout mid-frame.
    ticks(2);
    drive(1'b0, 1'b0, 4'hF, 1'b0);
    drive(1'b0, 1'b1, 4'hE, 1'b0);
    cmp("notick.idx", int'(idx0), 2);
    ticks(3);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 4'hF, 1'b0);
    cmp("dropout.hold", int'(idx0), 5);
    drive(1'b0, 1'b1, 4'hF, 1'b0);
    cmp("dropout.resume", int'(idx0), 6);
    drive(1'b0, 1'b0, 4'h0, 1'b1);

    // Tick landing in the completion cycle is ignored.
    ticks(10);
    drive(1'b0, 1'b1, 4'hF, 1'b0);
    cmp("donetick.idx", int'(idx0), 0);
    cmp("donetick.char", int'(chr0), 1);
    cmp("donetick.no_strobe", int'(stb0), 0);
    idle();
    cmp("donetick.not_counted", int'(idx0), 0);
    idle();
    drive(1'b0, 1'b0, 4'h0, 1'b1);

    // Flag in the completion cycle suppresses char_rs.
    ticks(10);
    drive(1'b0, 1'b0, 4'h0, 1'b1);
    cmp("doneflag.char", int'(chr0), 0);
    cmp("doneflag.err", int'(ab0), 1);
    cmp("doneflag.idx", int'(idx0), 0);
    idle();
    cmp("doneflag.char_later", int'(chr0), 0);
    drive(1'b0, 1'b0, 4'h0, 1'b1);

    // Reset mid-frame.
    ticks(7);
    cmp("midrst.pre", int'(idx0), 7);
    drive(1'b1, 1'b1, 4'hF, 1'b1);
    cmp("midrst.idx", int'(idx0), 0);
    cmp("midrst.strobe", int'(stb0), 0);
    cmp("midrst.abort", int'(ab0), 0);
    cmp("midrst.busy", int'(busy0), 0);

    // Illegal count deposited while counting.
    ticks(3);
    d0.count <= 4'd12;
    m0.idx = 12;
    idle();
    cmp("illegal.idx", int'(idx0), 0);
    cmp("illegal.busy", int'(busy0), 0);
    cmp("illegal.strobe", int'(stb0), 0);
    cmp("illegal.char", int'(chr0), 0);
    cmp("illegal.abort", int'(ab0), 0);
    drive(1'b0, 1'b0, 4'h0, 1'b1);

    // Random soak.
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 299) == 0),
            1'($urandom_range(0, 3) != 0),
            ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 14)),
            1'($urandom_range(0, 79) == 0));
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
